// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the seq_ctrl operation sequencer: state encoding and counter clear value.
// Used by seq_ctrl (optional abort port via SEQ_CTRL_ABORT_EN) and iter_counter.
package seq_ctrl_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_LOAD = LOAD,
        S_RUN  = RUN,
        S_DONE = DONE
    } state_t;

    // Wide enough for any counter width; users slice the low CW bits.
    localparam logic [31:0] CNT_CLR = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_ctrl_iter_counter.sv
// Clear/count-up iteration counter; clear and reset both load all-ones, clear beats count.
module iter_counter
    import seq_ctrl_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          clr_i,
    input  logic          c_up_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cnt_q <= CNT_CLR[CW-1:0];
        end else if (clr_i) begin
            cnt_q <= CNT_CLR[CW-1:0];
        end else if (c_up_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_ctrl.sv
// Multicycle operation sequencer: IDLE -> LOAD -> RUN (STEPS steps) -> DONE.
// Define SEQ_CTRL_ABORT_EN to add the abort input that cancels LOAD/RUN back to IDLE.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int STEPS = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic          stall,
`ifdef SEQ_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic          ld,
    output logic          clr_cnt,
    output logic          c_up,
    output logic          step,
    output logic [CW-1:0] idx,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] LAST_IDX = CW'(STEPS - 1);

    state_t        state_q;
    logic [CW-1:0] cnt;
    logic          abort_act;
    logic          in_load;
    logic          in_run;

    assign in_load = (state_q == S_LOAD);
    assign in_run  = (state_q == S_RUN);

`ifdef SEQ_CTRL_ABORT_EN
    assign abort_act = abort && (in_load || in_run);
`else
    assign abort_act = 1'b0;
`endif

    // The counter sits at all-ones after clear, so idx reads 0 on the first RUN cycle.
    assign idx     = cnt + CW'(1);
    assign step    = in_run && !stall && !abort_act;
    assign c_up    = step;
    assign ld      = in_load && !abort_act;
    assign clr_cnt = in_load;
    assign busy    = in_load || in_run;
    assign done    = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
        end else if (abort_act) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start) state_q <= S_LOAD;
                S_LOAD: state_q <= S_RUN;
                S_RUN:  if (step && (idx == LAST_IDX)) state_q <= S_DONE;
                S_DONE: state_q <= S_IDLE;
            endcase
        end
    end

    iter_counter #(
        .CW(CW)
    ) u_iter_counter (
        .clk   (clk),
        .rst_b (rst_b),
        .clr_i (clr_cnt),
        .c_up_i(c_up),
        .cnt_o (cnt)
    );

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed scoreboard bench for seq_ctrl: an 8-step and a 16-step (wrap) instance share clock/reset.
// Build with SEQ_CTRL_ABORT_EN to also exercise the abort path.
module tb_seq_ctrl;

    localparam int STEPS_A = 8;
    localparam int STEPS_B = 16;
    localparam int CW      = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b, start_a, start_b, stall;
`ifdef SEQ_CTRL_ABORT_EN
    logic abort;
`endif

    logic          ld_a, clr_cnt_a, c_up_a, step_a, busy_a, done_a;
    logic [CW-1:0] idx_a;
    logic          ld_b, clr_cnt_b, c_up_b, step_b, busy_b, done_b;
    logic [CW-1:0] idx_b;

    int ntot  = 0;
    int npass = 0;
    int nfail = 0;
    int qa[$];
    int qb[$];

    seq_ctrl #(.STEPS(STEPS_A), .CW(CW)) dut_a (
        .clk(clk), .rst_b(rst_b), .start(start_a), .stall(stall),
`ifdef SEQ_CTRL_ABORT_EN
        .abort(abort),
`endif
        .ld(ld_a), .clr_cnt(clr_cnt_a), .c_up(c_up_a), .step(step_a),
        .idx(idx_a), .busy(busy_a), .done(done_a)
    );

    seq_ctrl #(.STEPS(STEPS_B), .CW(CW)) dut_b (
        .clk(clk), .rst_b(rst_b), .start(start_b), .stall(1'b0),
`ifdef SEQ_CTRL_ABORT_EN
        .abort(1'b0),
`endif
        .ld(ld_b), .clr_cnt(clr_cnt_b), .c_up(c_up_b), .step(step_b),
        .idx(idx_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the expected idx for every step the DUT takes.
    task automatic sample_a();
        if (step_a) begin
            chk("a_cup_eq_step", 32'(c_up_a), 32'(1));
            if (qa.size() == 0) chk("a_extra_step", 32'(step_a), 32'(0));
            else                chk("a_step_idx", 32'(idx_a), 32'(qa.pop_front()));
        end
    endtask

    task automatic sample_b();
        if (step_b) begin
            if (qb.size() == 0) chk("b_extra_step", 32'(step_b), 32'(0));
            else                chk("b_step_idx", 32'(idx_b), 32'(qb.pop_front()));
        end
    endtask

    task automatic run_a(input int stall_idx, input int stall_len, input bit hold,
                         output int done_n, output int busy_n);
        int st;
        st     = 0;
        done_n = -1;
        busy_n = 0;
        for (int i = 0; i < STEPS_A; i++) qa.push_back(i);
        start_a = 1'b1;
        for (int n = 1; n <= 40 && done_n < 0; n++) begin
            tick();
            if (n == 1 && !hold) start_a = 1'b0;
            stall = busy_a && !ld_a && (32'(idx_a) == stall_idx) && (st < stall_len);
            if (stall) st++;
            #1;
            if (n == 1) chk("a_load_flags", 32'({ld_a, clr_cnt_a, busy_a, step_a}), 32'(4'b1110));
            if (stall) begin
                chk("a_stall_step", 32'(step_a), 32'(0));
                chk("a_stall_idx", 32'(idx_a), 32'(stall_idx));
            end
            sample_a();
            if (busy_a) busy_n++;
            if (done_a) done_n = n;
        end
        stall = 1'b0;
        chk("a_queue_drained", 32'(qa.size()), 32'(0));
    endtask

    initial begin
        int d, b;
        bit found;
        rst_b   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        stall   = 1'b0;
`ifdef SEQ_CTRL_ABORT_EN
        abort   = 1'b0;
`endif
        tick();
        tick();
        chk("reset_outs_a", 32'({ld_a, clr_cnt_a, step_a, c_up_a, busy_a, done_a}), 32'(0));
        chk("reset_idx_a", 32'(idx_a), 32'(0));
        chk("reset_outs_b", 32'({ld_b, clr_cnt_b, step_b, c_up_b, busy_b, done_b, idx_b}), 32'(0));
        rst_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_outs", 32'({ld_a, clr_cnt_a, step_a, c_up_a, busy_a, done_a, idx_a}), 32'(0));
        end

        // Basic run
        run_a(-1, 0, 1'b0, d, b);
        chk("basic_done_cycle", 32'(d), 32'(10));
        chk("basic_busy_cycles", 32'(b), 32'(9));
        tick();
        chk("basic_done_single", 32'({done_a, busy_a}), 32'(0));

        // Stall three cycles at idx 4
        run_a(4, 3, 1'b0, d, b);
        chk("stall_done_cycle", 32'(d), 32'(13));
        chk("stall_busy_cycles", 32'(b), 32'(12));
        tick();

        // Wrap boundary on the 16-step instance
        for (int i = 0; i < STEPS_B; i++) qb.push_back(i);
        start_b = 1'b1;
        d = -1;
        for (int n = 1; n <= 40 && d < 0; n++) begin
            tick();
            if (n == 1) start_b = 1'b0;
            sample_b();
            if (done_b) begin
                d = n;
                chk("wrap_cnt_allones", 32'(idx_b), 32'(0));
            end
        end
        chk("wrap_done_cycle", 32'(d), 32'(18));
        chk("wrap_queue_drained", 32'(qb.size()), 32'(0));
        tick();
        chk("wrap_after_done", 32'({step_b, done_b, busy_b}), 32'(0));

        // Back-to-back with start held, then reset mid-operation
        run_a(-1, 0, 1'b1, d, b);
        chk("b2b_first_done", 32'(d), 32'(10));
        tick();
        chk("b2b_idle_gap", 32'({busy_a, ld_a, done_a}), 32'(0));
        tick();
        chk("b2b_second_load", 32'(ld_a), 32'(1));
        start_a = 1'b0;
        for (int i = 0; i < STEPS_A; i++) qa.push_back(i);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            sample_a();
            if (step_a && idx_a == 4'd3) found = 1'b1;
        end
        chk("midrst_reached_idx3", 32'(found), 32'(1));
        rst_b = 1'b0;
        tick();
        chk("midrst_outs", 32'({ld_a, clr_cnt_a, step_a, c_up_a, busy_a, done_a, idx_a}), 32'(0));
        rst_b = 1'b1;
        qa.delete();
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("midrst_no_done", 32'({done_a, busy_a}), 32'(0));
        end

`ifdef SEQ_CTRL_ABORT_EN
        for (int i = 0; i < STEPS_A; i++) qa.push_back(i);
        start_a = 1'b1;
        found = 1'b0;
        for (int n = 1; n <= 20 && !found; n++) begin
            tick();
            if (n == 1) start_a = 1'b0;
            if (busy_a && !ld_a && idx_a == 4'd2) begin
                abort = 1'b1;
                found = 1'b1;
            end
            #1;
            if (abort) chk("abort_step", 32'({step_a, c_up_a}), 32'(0));
            else       sample_a();
        end
        chk("abort_reached_idx2", 32'(found), 32'(1));
        tick();
        abort = 1'b0;
        chk("abort_idle", 32'({busy_a, done_a, step_a}), 32'(0));
        qa.delete();
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_no_done", 32'(done_a), 32'(0));
        end
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
